// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path and hex-line loader.
package uart_pkg;

    // Line terminators accepted by the loader.
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    // Receiver FSM encodings.
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Line parser FSM encodings.
    localparam logic [1:0] PS_HEX      = 2'd0;
    localparam logic [1:0] PS_WAIT_EOL = 2'd1;
    localparam logic [1:0] PS_SKIP     = 2'd2;

    // Clocks per bit period; integer division, result must be >= 4.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // ASCII hex digit decode: {valid, nibble}.
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        logic [7:0] t;
        t = 8'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            t = c - 8'h30;
            return {1'b1, t[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            t = c - 8'h37;
            return {1'b1, t[3:0]};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            t = c - 8'h57;
            return {1'b1, t[3:0]};
        end
        return 5'b0_0000;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch rejection
// on the start bit and framing-error reporting on a low stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic [1:0] state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_sync_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Bring the asynchronous line into the clock domain; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Next-state logic: start-bit qualify at half period, then full-period samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // A line that is high again mid start bit was only a glitch.
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync_q, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        valid_d = 1'b1;
                        data_d  = shreg_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign state     = state_q;

endmodule

// File: rtl/uart_hex_loader.sv
// Parses "XXXXXXXX" + CR/LF lines from the UART into 32-bit word writes at
// an auto-incrementing byte address. Bytes arrive as one-cycle valid pulses;
// wr_en and err are one-cycle pulses and never coincide.
module uart_hex_loader
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int ADDR_STEP    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        err,
    output logic        rx_busy
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic [1:0] rx_state;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (rx_data),
        .valid    (rx_valid),
        .frame_err(rx_ferr),
        .state    (rx_state)
    );

    assign rx_busy = (rx_state != RX_IDLE);

    logic [1:0]  ps_q, ps_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        err_q, err_d;
    logic [4:0]  hv;
    logic        is_eol;

    // Line parser: accumulate eight digits, commit on terminator, resync on junk.
    always_comb begin
        hv        = hex_val(rx_data);
        is_eol    = (rx_data == CR) || (rx_data == LF);
        ps_d      = ps_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // A framing error yields no byte, so it cannot collide with a parser event.
        err_d     = rx_ferr;
        if (rx_valid) begin
            case (ps_q)
                PS_HEX: begin
                    if (hv[4]) begin
                        acc_d = {acc_q[27:0], hv[3:0]};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) ps_d = PS_WAIT_EOL;
                    end else if (is_eol) begin
                        // Empty lines and the second half of CRLF are silent.
                        if (cnt_q != 4'd0) begin
                            err_d = 1'b1;
                            cnt_d = 4'd0;
                        end
                    end else begin
                        err_d = 1'b1;
                        ps_d  = PS_SKIP;
                    end
                end
                PS_WAIT_EOL: begin
                    if (is_eol) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = acc_q;
                        wr_addr_d = addr_q;
                        addr_d    = addr_q + 32'(ADDR_STEP);
                        cnt_d     = 4'd0;
                        ps_d      = PS_HEX;
                    end else begin
                        err_d = 1'b1;
                        ps_d  = PS_SKIP;
                    end
                end
                PS_SKIP: begin
                    if (is_eol) begin
                        cnt_d = 4'd0;
                        ps_d  = PS_HEX;
                    end
                end
                default: ps_d = PS_HEX;
            endcase
        end
    end

    // Parser and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q      <= PS_HEX;
            cnt_q     <= 4'd0;
            acc_q     <= 32'h0;
            addr_q    <= 32'h0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 32'h0;
            wr_data_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            ps_q      <= ps_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Bench for uart_hex_loader: table of whole lines plus hand sequences for
// framing error, start-bit glitch and reset in the middle of a frame.
module tb_uart_hex_loader;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        err;
    logic        rx_busy;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    bit busy_seen = 1'b0;
    logic [63:0] exp_q[$];

    typedef struct {
        string       line;
        bit          rst_before;
        int          exp_err;
        bit          exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    uart_hex_loader #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000),
        .ADDR_STEP(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .err    (err),
        .rx_busy(rx_busy)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Output monitor / scoreboard, sampling away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_busy) busy_seen = 1'b1;
            if (err) err_cnt++;
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr %h data %h required none", wr_addr, wr_data);
                end else begin
                    check("write", {wr_addr, wr_data}, exp_q.pop_front());
                end
                check("err_with_wr_en", {63'd0, err}, 64'd0);
            end
        end
    end

    // Driver tasks.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (30) @(negedge clk);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_wr_en"},   {63'd0, wr_en},   64'd0);
        check({name, "_wr_addr"}, {32'd0, wr_addr}, 64'd0);
        check({name, "_wr_data"}, {32'd0, wr_data}, 64'd0);
        check({name, "_err"},     {63'd0, err},     64'd0);
        check({name, "_rx_busy"}, {63'd0, rx_busy}, 64'd0);
    endtask

    initial begin
        int err0;

        vecs[0] = '{"00500093\015\012",    1'b0, 0, 1'b1, 32'h0, 32'h0050_0093};
        vecs[1] = '{"deadBEEF\012",        1'b0, 0, 1'b1, 32'h4, 32'hDEAD_BEEF};
        vecs[2] = '{"\015\012\015\012",    1'b0, 0, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{"0050G093\015\012",    1'b1, 1, 1'b0, 32'h0, 32'h0};
        vecs[4] = '{"00000013\012",        1'b0, 0, 1'b1, 32'h0, 32'h0000_0013};
        vecs[5] = '{"1234\015",            1'b1, 1, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{"123456789\012",       1'b0, 1, 1'b0, 32'h0, 32'h0};
        vecs[7] = '{"0000abcd\012",        1'b0, 0, 1'b1, 32'h0, 32'h0000_ABCD};

        do_reset();
        check_reset_values("reset");

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst_before) do_reset();
            err0 = err_cnt;
            if (vecs[v].exp_wr) exp_q.push_back({vecs[v].exp_addr, vecs[v].exp_data});
            send_str(vecs[v].line);
            wait_drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_err_count", v), 64'(err_cnt - err0), 64'(vecs[v].exp_err));
        end

        // Framing error between digits: flagged, byte dropped, digit count kept.
        err0 = err_cnt;
        exp_q.push_back({32'h4, 32'h1234_5678});
        send_str("12");
        send_byte(8'h41, 1'b0);
        repeat (30) @(negedge clk);
        check("frame_err_count", 64'(err_cnt - err0), 64'd1);
        send_str("345678\015");
        wait_drain("frame_err_line");
        check("frame_err_total_err", 64'(err_cnt - err0), 64'd1);

        // Short low glitch: brief busy only, no error, no write.
        err0 = err_cnt;
        busy_seen = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_seen", {63'd0, busy_seen}, 64'd1);
        check("glitch_busy_low",  {63'd0, rx_busy}, 64'd0);
        check("glitch_err_count", 64'(err_cnt - err0), 64'd0);

        // Reset during a partial line and a partial byte.
        send_str("0050");
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            repeat (CPB) @(negedge clk);
        end
        do_reset();
        check_reset_values("midframe_reset");
        err0 = err_cnt;
        exp_q.push_back({32'h0, 32'h0000_0073});
        send_str("00000073\015");
        wait_drain("after_reset");
        check("after_reset_err_count", 64'(err_cnt - err0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
